autosa_rbk_csb2reg_master: RTL and testbench

//  Initiator side of the Rubik single-register interface (reg_offset / reg_wr_data / reg_wr_en / reg_rd_data).
//  - Accepts one CSB-style request at a time (valid/ready) and decodes the block base address.
//  - Drives one register access cycle into the Rubik register block.
//  - Returns read data, or non-posted write completion, on a valid/ready response channel.

---
 rtl/autosa_rbk_pkg.sv | 37 +++
 rtl/autosa_rbk_csb2reg_master.sv | 182 ++++++++++++++++++
 tb/tb_autosa_rbk_csb2reg_master.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/autosa_rbk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : autosa_rbk_pkg
// Purpose  : Shared types, widths and the block-base decode helper for the
//            Rubik CSB-to-register master.
// Contents : rbk_state_e     - master FSM state encoding
//            RBK_OFFSET_W    - register offset width (12)
//            RBK_DATA_W      - register data width (32)
//            rbk_addr_hit()  - compares address bits [addr_w-1:12] to a base
// Revision : 1.0 - initial release
// ============================================================================
package autosa_rbk_pkg;

   localparam int RBK_OFFSET_W = 12;
   localparam int RBK_DATA_W   = 32;

   // RBK_RDPIPE is only reachable when AUTOSA_RBK_RD_PIPE_EN is defined.
   typedef enum logic [1:0] {
      RBK_IDLE   = 2'd0,
      RBK_ACCESS = 2'd1,
      RBK_RDPIPE = 2'd2,
      RBK_RESP   = 2'd3
   } rbk_state_e;

   // Block hit when every address bit above the 4 KiB page offset, up to
   // addr_w-1, matches the base. Operands are zero-extended to 64 bits so a
   // single function serves any ADDR_W up to 64.
   function automatic logic rbk_addr_hit(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned addr_w);
      logic [63:0] mask;
      mask = ((64'd1 << addr_w) - 64'd1) & ~64'hFFF;
      return ((addr ^ base) & mask) == 64'd0;
   endfunction

endpackage : autosa_rbk_pkg
`default_nettype wire

// File: rtl/autosa_rbk_csb2reg_master.sv
`default_nettype none
// ============================================================================
// Module   : autosa_rbk_csb2reg_master
// Purpose  : Initiator side of the Rubik single-register interface. Accepts
//            one CSB request at a time, decodes the block base, performs one
//            register access and returns read data / non-posted write
//            completion on a valid/ready response channel.
// Config   : AUTOSA_RBK_RD_PIPE_EN - when defined, read data is registered
//            once more (ACCESS -> RDPIPE -> RESP), moving read rsp_valid one
//            cycle later. Writes are unaffected.
// Ports    : autosa_core_clk / autosa_core_rstn (async, active-low)
//            req_*   : request channel (valid/ready), addr/write/wdat/nposted
//            rsp_*   : response channel (valid/ready), rd_data/is_write/error
//            reg_*   : register block side (offset, wr_data, wr_en, rd_data)
//            err_cnt : saturating count of decode misses
// Revision : 1.0 - initial release
// ============================================================================
module autosa_rbk_csb2reg_master
   import autosa_rbk_pkg::*;
#(
   parameter int unsigned         ADDR_W    = 24,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = 'h10000,
   parameter int unsigned         ERR_CNT_W = 8
) (
   input  logic                    autosa_core_clk,
   input  logic                    autosa_core_rstn,
   input  logic                    req_pvld,
   output logic                    req_prdy,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic                    req_write,
   input  logic [RBK_DATA_W-1:0]   req_wdat,
   input  logic                    req_nposted,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [RBK_DATA_W-1:0]   rsp_rd_data,
   output logic                    rsp_is_write,
   output logic                    rsp_error,
   output logic [RBK_OFFSET_W-1:0] reg_offset,
   output logic [RBK_DATA_W-1:0]   reg_wr_data,
   output logic                    reg_wr_en,
   input  logic [RBK_DATA_W-1:0]   reg_rd_data,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   rbk_state_e              state_q, state_d;
   logic [RBK_OFFSET_W-1:0] reg_offset_q, reg_offset_d;
   logic [RBK_DATA_W-1:0]   reg_wr_data_q, reg_wr_data_d;
   logic                    write_q, write_d;
   logic                    nposted_q, nposted_d;
   logic                    hit_q, hit_d;
   logic [RBK_DATA_W-1:0]   rsp_rd_data_q, rsp_rd_data_d;
   logic                    rsp_is_write_q, rsp_is_write_d;
   logic                    rsp_error_q, rsp_error_d;
   logic [ERR_CNT_W-1:0]    err_cnt_q, err_cnt_d;
`ifdef AUTOSA_RBK_RD_PIPE_EN
   logic [RBK_DATA_W-1:0]   rd_pipe_q, rd_pipe_d;
`endif

   logic                    req_hit;
   logic [RBK_DATA_W-1:0]   rd_sel;

   assign req_hit = rbk_addr_hit(64'(req_addr), 64'(BASE_ADDR), ADDR_W);

   // Only a read that hit may sample the register block; everything else
   // returns zero data.
   assign rd_sel = (hit_q && !write_q) ? reg_rd_data : '0;

   always_comb begin
      state_d        = state_q;
      reg_offset_d   = reg_offset_q;
      reg_wr_data_d  = reg_wr_data_q;
      write_d        = write_q;
      nposted_d      = nposted_q;
      hit_d          = hit_q;
      rsp_rd_data_d  = rsp_rd_data_q;
      rsp_is_write_d = rsp_is_write_q;
      rsp_error_d    = rsp_error_q;
      err_cnt_d      = err_cnt_q;
`ifdef AUTOSA_RBK_RD_PIPE_EN
      rd_pipe_d      = rd_pipe_q;
`endif

      case (state_q)
         RBK_IDLE: begin
            if (req_pvld) begin
               reg_offset_d  = req_addr[RBK_OFFSET_W-1:0];
               reg_wr_data_d = req_wdat;
               write_d       = req_write;
               nposted_d     = req_nposted;
               hit_d         = req_hit;
               state_d       = RBK_ACCESS;
            end
         end

         RBK_ACCESS: begin
            rsp_is_write_d = write_q;
            rsp_error_d    = ~hit_q;
            if (!hit_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
               err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
`ifdef AUTOSA_RBK_RD_PIPE_EN
            rd_pipe_d     = rd_sel;
            rsp_rd_data_d = '0;
`else
            rsp_rd_data_d = rd_sel;
`endif
            if (write_q && !nposted_q) begin
               state_d = RBK_IDLE;
            end else begin
`ifdef AUTOSA_RBK_RD_PIPE_EN
               state_d = write_q ? RBK_RESP : RBK_RDPIPE;
`else
               state_d = RBK_RESP;
`endif
            end
         end

`ifdef AUTOSA_RBK_RD_PIPE_EN
         RBK_RDPIPE: begin
            rsp_rd_data_d = rd_pipe_q;
            state_d       = RBK_RESP;
         end
`endif

         RBK_RESP: begin
            if (rsp_ready) begin
               state_d = RBK_IDLE;
            end
         end

         default: begin
            state_d = RBK_IDLE;
         end
      endcase
   end

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         state_q        <= RBK_IDLE;
         reg_offset_q   <= '0;
         reg_wr_data_q  <= '0;
         write_q        <= 1'b0;
         nposted_q      <= 1'b0;
         hit_q          <= 1'b0;
         rsp_rd_data_q  <= '0;
         rsp_is_write_q <= 1'b0;
         rsp_error_q    <= 1'b0;
         err_cnt_q      <= '0;
`ifdef AUTOSA_RBK_RD_PIPE_EN
         rd_pipe_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         reg_offset_q   <= reg_offset_d;
         reg_wr_data_q  <= reg_wr_data_d;
         write_q        <= write_d;
         nposted_q      <= nposted_d;
         hit_q          <= hit_d;
         rsp_rd_data_q  <= rsp_rd_data_d;
         rsp_is_write_q <= rsp_is_write_d;
         rsp_error_q    <= rsp_error_d;
         err_cnt_q      <= err_cnt_d;
`ifdef AUTOSA_RBK_RD_PIPE_EN
         rd_pipe_q      <= rd_pipe_d;
`endif
      end
   end

   // The write strobe is decoded from state flops so that an asynchronous
   // reset removes it immediately, without waiting for a clock edge.
   assign reg_wr_en    = (state_q == RBK_ACCESS) && write_q && hit_q;
   assign req_prdy     = (state_q == RBK_IDLE);
   assign rsp_valid    = (state_q == RBK_RESP);
   assign reg_offset   = reg_offset_q;
   assign reg_wr_data  = reg_wr_data_q;
   assign rsp_rd_data  = rsp_rd_data_q;
   assign rsp_is_write = rsp_is_write_q;
   assign rsp_error    = rsp_error_q;
   assign err_cnt      = err_cnt_q;

endmodule : autosa_rbk_csb2reg_master
`default_nettype wire

// File: tb/tb_autosa_rbk_csb2reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_autosa_rbk_csb2reg_master
// Purpose  : Directed bench for autosa_rbk_csb2reg_master with a small
//            SA-side Rubik register block as target:
//              0x000 : read-only {14'b0, status_1, 14'b0, status_0}
//              0x004 : producer bit (read/write, bit 0)
// Config   : honours AUTOSA_RBK_RD_PIPE_EN for read response latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_autosa_rbk_csb2reg_master;

`ifdef AUTOSA_RBK_RD_PIPE_EN
   localparam int RD_EXTRA = 1;
`else
   localparam int RD_EXTRA = 0;
`endif

   logic        clk;
   logic        rstn;
   logic        req_pvld;
   logic        req_prdy;
   logic [23:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdat;
   logic        req_nposted;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rd_data;
   logic        rsp_is_write;
   logic        rsp_error;
   logic [11:0] reg_offset;
   logic [31:0] reg_wr_data;
   logic        reg_wr_en;
   logic [31:0] reg_rd_data;
   logic [7:0]  err_cnt;

   // Target register block
   logic [1:0]  status_0;
   logic [1:0]  status_1;
   logic        producer;

   int n_cmp = 0;
   int n_mis = 0;

   autosa_rbk_csb2reg_master #(
      .ADDR_W    (24),
      .BASE_ADDR (24'h010000),
      .ERR_CNT_W (8)
   ) dut (
      .autosa_core_clk  (clk),
      .autosa_core_rstn (rstn),
      .req_pvld         (req_pvld),
      .req_prdy         (req_prdy),
      .req_addr         (req_addr),
      .req_write        (req_write),
      .req_wdat         (req_wdat),
      .req_nposted      (req_nposted),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rd_data      (rsp_rd_data),
      .rsp_is_write     (rsp_is_write),
      .rsp_error        (rsp_error),
      .reg_offset       (reg_offset),
      .reg_wr_data      (reg_wr_data),
      .reg_wr_en        (reg_wr_en),
      .reg_rd_data      (reg_rd_data),
      .err_cnt          (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      reg_rd_data = 32'h0;
      case (reg_offset)
         12'h000: reg_rd_data = {14'b0, status_1, 14'b0, status_0};
         12'h004: reg_rd_data = {31'b0, producer};
         default: reg_rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         producer <= 1'b0;
      end else if (reg_wr_en && reg_offset == 12'h004) begin
         producer <= reg_wr_data[0];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for rsp_valid, sampling 1 time unit after each edge.
   task automatic wait_rsp(input int max_cyc, output logic seen, output int cycles);
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < max_cyc; i++) begin
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
         cycles++;
      end
      if (!seen && rsp_valid) seen = 1'b1;
   endtask

   task automatic drive_req(input logic [23:0] a, input logic w,
                            input logic [31:0] d, input logic np);
      req_addr    = a;
      req_write   = w;
      req_wdat    = d;
      req_nposted = np;
      req_pvld    = 1'b1;
   endtask

   initial begin
      logic seen;
      int   cyc;

      rstn        = 1'b0;
      req_pvld    = 1'b0;
      req_addr    = '0;
      req_write   = 1'b0;
      req_wdat    = '0;
      req_nposted = 1'b0;
      rsp_ready   = 1'b0;
      status_0    = 2'b00;
      status_1    = 2'b00;

      // ---- reset state ----
      #12;
      chk("rst_req_prdy",     req_prdy,     1);
      chk("rst_rsp_valid",    rsp_valid,    0);
      chk("rst_reg_wr_en",    reg_wr_en,    0);
      chk("rst_reg_offset",   reg_offset,   0);
      chk("rst_reg_wr_data",  reg_wr_data,  0);
      chk("rst_rsp_rd_data",  rsp_rd_data,  0);
      chk("rst_rsp_is_write", rsp_is_write, 0);
      chk("rst_rsp_error",    rsp_error,    0);
      chk("rst_err_cnt",      err_cnt,      0);
      tick();
      rstn = 1'b1;
      tick();

      // ---- 1: posted write hit 0x10004 <= 1 ----
      drive_req(24'h010004, 1'b1, 32'h1, 1'b0);
      @(negedge clk);
      chk("t1_prdy_T", req_prdy, 1);
      tick();                                   // T+1
      req_pvld = 1'b0;
      chk("t1_wr_en_T1",    reg_wr_en,  1);
      chk("t1_offset_T1",   reg_offset, 12'h004);
      chk("t1_wdata_T1",    reg_wr_data, 32'h1);
      chk("t1_prdy_T1",     req_prdy,   0);
      chk("t1_producer_T1", producer,   0);
      tick();                                   // T+2
      chk("t1_wr_en_T2",    reg_wr_en,  0);
      chk("t1_producer_T2", producer,   1);
      chk("t1_rsp_valid",   rsp_valid,  0);
      chk("t1_prdy_T2",     req_prdy,   1);
      tick();
      chk("t1_no_rsp",      rsp_valid,  0);

      // ---- 2: read hit 0x10000, status registers ----
      status_0 = 2'b10;
      status_1 = 2'b01;
      drive_req(24'h010000, 1'b0, 32'h0, 1'b0);
      tick();                                   // T+1
      req_pvld = 1'b0;
      chk("t2_wr_en_T1",     reg_wr_en, 0);
      chk("t2_rsp_valid_T1", rsp_valid, 0);
      tick();                                   // T+2
      if (RD_EXTRA != 0) begin
         chk("t2_rsp_valid_pipe", rsp_valid, 0);
         tick();                                // T+3
      end
      chk("t2_rsp_valid",    rsp_valid,    1);
      chk("t2_rsp_rd_data",  rsp_rd_data,  32'h0001_0002);
      chk("t2_rsp_error",    rsp_error,    0);
      chk("t2_rsp_is_write", rsp_is_write, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t2_rsp_done",  rsp_valid, 0);
      chk("t2_prdy_back", req_prdy,  1);

      // ---- 3: non-posted write miss 0x20004 ----
      drive_req(24'h020004, 1'b1, 32'h0000_DEAD, 1'b1);
      tick();                                   // T+1
      req_pvld = 1'b0;
      chk("t3_wr_en_T1",   reg_wr_en, 0);
      chk("t3_err_cnt_T1", err_cnt,   0);
      tick();                                   // T+2
      chk("t3_rsp_valid",    rsp_valid,    1);
      chk("t3_rsp_error",    rsp_error,    1);
      chk("t3_rsp_is_write", rsp_is_write, 1);
      chk("t3_rsp_rd_data",  rsp_rd_data,  0);
      chk("t3_err_cnt",      err_cnt,      1);
      chk("t3_producer",     producer,     1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t3_rsp_done", rsp_valid, 0);

      // ---- 4: read hit 0x10004 with 5 cycles of backpressure ----
      drive_req(24'h010004, 1'b0, 32'h0, 1'b0);
      tick();                                   // accepted
      drive_req(24'h010000, 1'b0, 32'h0, 1'b0); // second request held pending
      wait_rsp(8, seen, cyc);
      chk("t4_rsp_seen", seen, 1);
      chk("t4_latency",  cyc,  1 + RD_EXTRA);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", rsp_valid,   1);
         chk("t4_hold_data",  rsp_rd_data, 32'h1);
         chk("t4_hold_prdy",  req_prdy,    0);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_prdy_at_hs", req_prdy, 0);
      tick();                                   // handshake taken
      rsp_ready = 1'b0;
      chk("t4_rsp_done",   rsp_valid, 0);
      chk("t4_prdy_after", req_prdy,  1);
      tick();                                   // second request accepted
      req_pvld = 1'b0;
      chk("t4_second_accepted", req_prdy, 0);
      wait_rsp(8, seen, cyc);
      chk("t4_second_seen", seen,        1);
      chk("t4_second_data", rsp_rd_data, 32'h0001_0002);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ---- 5: reset during ACCESS of a non-posted write hit ----
      drive_req(24'h010004, 1'b1, 32'h0, 1'b1);
      tick();                                   // ACCESS
      req_pvld = 1'b0;
      chk("t5_wr_en_before", reg_wr_en, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("t5_wr_en_now",      reg_wr_en,    0);
      chk("t5_rsp_valid",      rsp_valid,    0);
      chk("t5_prdy",           req_prdy,     1);
      chk("t5_offset",         reg_offset,   0);
      chk("t5_wr_data",        reg_wr_data,  0);
      chk("t5_rsp_rd_data",    rsp_rd_data,  0);
      chk("t5_rsp_is_write",   rsp_is_write, 0);
      chk("t5_rsp_error",      rsp_error,    0);
      chk("t5_err_cnt",        err_cnt,      0);
      tick();
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_no_rsp_after", rsp_valid, 0);
         chk("t5_prdy_after",   req_prdy,  1);
      end

      // ---- 6: 300 miss reads, err_cnt saturates at 255 ----
      for (int k = 1; k <= 300; k++) begin
         drive_req(24'h030000, 1'b0, 32'h0, 1'b0);
         tick();
         req_pvld = 1'b0;
         wait_rsp(8, seen, cyc);
         chk("t6_rsp_seen",  seen,        1);
         chk("t6_rsp_error", rsp_error,   1);
         chk("t6_rsp_data",  rsp_rd_data, 0);
         chk("t6_err_cnt",   err_cnt,     (k > 255) ? 32'd255 : 32'(k));
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
      chk("t6_err_cnt_final", err_cnt, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_autosa_rbk_csb2reg_master
`default_nettype wire
